// File: rtl/nasti_demux_pkg.sv
// Shared types and constants for the NASTI address-decoding demux.
package nasti_demux_pkg;

    localparam int unsigned N_LANES = 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef logic [2:0] lane_t;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_ERR_DATA, W_ERR_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_ERR} r_state_t;

endpackage

// File: rtl/nasti_demux_decode.sv
// Address -> {hit, sel}: lowest active lane whose masked address matches its base wins.
module nasti_demux_decode
    import nasti_demux_pkg::*;
#(
    parameter int unsigned PORT_NUM   = 4,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned BASE0 = 'h00, BASE1 = 'h20, BASE2 = 'h40, BASE3 = 'h60,
    parameter int unsigned BASE4 = 'h00, BASE5 = 'h00, BASE6 = 'h00, BASE7 = 'h00,
    parameter int unsigned MASK0 = 'hE0, MASK1 = 'hE0, MASK2 = 'hE0, MASK3 = 'hE0,
    parameter int unsigned MASK4 = 'hE0, MASK5 = 'hE0, MASK6 = 'hE0, MASK7 = 'hE0
) (
    input  logic [ADDR_WIDTH-1:0] addr_i,
    output logic                  hit_o,
    output logic [2:0]            sel_o
);

    localparam logic [ADDR_WIDTH-1:0] BASES [N_LANES] = '{
        ADDR_WIDTH'(BASE0), ADDR_WIDTH'(BASE1), ADDR_WIDTH'(BASE2), ADDR_WIDTH'(BASE3),
        ADDR_WIDTH'(BASE4), ADDR_WIDTH'(BASE5), ADDR_WIDTH'(BASE6), ADDR_WIDTH'(BASE7)};
    localparam logic [ADDR_WIDTH-1:0] MASKS [N_LANES] = '{
        ADDR_WIDTH'(MASK0), ADDR_WIDTH'(MASK1), ADDR_WIDTH'(MASK2), ADDR_WIDTH'(MASK3),
        ADDR_WIDTH'(MASK4), ADDR_WIDTH'(MASK5), ADDR_WIDTH'(MASK6), ADDR_WIDTH'(MASK7)};

    always_comb begin
        hit_o = 1'b0;
        sel_o = '0;
        for (int unsigned i = 0; i < N_LANES; i++) begin
            if (!hit_o && (i < PORT_NUM) && ((addr_i & MASKS[i]) == BASES[i])) begin
                hit_o = 1'b1;
                sel_o = 3'(i);
            end
        end
    end

endmodule

// File: rtl/nasti_demux.sv
// One NASTI slave stream fanned out to up to 8 master lanes by address; zero-latency routing.
// NASTI_DEMUX_DECERR_EN: unmapped addresses hit an internal DECERR responder (else lane 0).
module nasti_demux
    import nasti_demux_pkg::*;
#(
    parameter int unsigned PORT_NUM   = 4,
    parameter int unsigned W_MAX      = 2,
    parameter int unsigned R_MAX      = 2,
    parameter int unsigned ID_WIDTH   = 1,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned USER_WIDTH = 1,
    parameter int unsigned BASE0 = 'h00, BASE1 = 'h20, BASE2 = 'h40, BASE3 = 'h60,
    parameter int unsigned BASE4 = 'h00, BASE5 = 'h00, BASE6 = 'h00, BASE7 = 'h00,
    parameter int unsigned MASK0 = 'hE0, MASK1 = 'hE0, MASK2 = 'hE0, MASK3 = 'hE0,
    parameter int unsigned MASK4 = 'hE0, MASK5 = 'hE0, MASK6 = 'hE0, MASK7 = 'hE0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_aw_valid_i,
    output logic                    s_aw_ready_o,
    input  logic [ID_WIDTH-1:0]     s_aw_id_i,
    input  logic [ADDR_WIDTH-1:0]   s_aw_addr_i,
    input  logic [7:0]              s_aw_len_i,
    input  logic [2:0]              s_aw_size_i,
    input  logic [1:0]              s_aw_burst_i,
    input  logic [USER_WIDTH-1:0]   s_aw_user_i,
    input  logic                    s_w_valid_i,
    output logic                    s_w_ready_o,
    input  logic [DATA_WIDTH-1:0]   s_w_data_i,
    input  logic [DATA_WIDTH/8-1:0] s_w_strb_i,
    input  logic                    s_w_last_i,
    input  logic [USER_WIDTH-1:0]   s_w_user_i,
    output logic                    s_b_valid_o,
    input  logic                    s_b_ready_i,
    output logic [ID_WIDTH-1:0]     s_b_id_o,
    output logic [1:0]              s_b_resp_o,
    output logic [USER_WIDTH-1:0]   s_b_user_o,
    input  logic                    s_ar_valid_i,
    output logic                    s_ar_ready_o,
    input  logic [ID_WIDTH-1:0]     s_ar_id_i,
    input  logic [ADDR_WIDTH-1:0]   s_ar_addr_i,
    input  logic [7:0]              s_ar_len_i,
    input  logic [2:0]              s_ar_size_i,
    input  logic [1:0]              s_ar_burst_i,
    input  logic [USER_WIDTH-1:0]   s_ar_user_i,
    output logic                    s_r_valid_o,
    input  logic                    s_r_ready_i,
    output logic [ID_WIDTH-1:0]     s_r_id_o,
    output logic [DATA_WIDTH-1:0]   s_r_data_o,
    output logic [1:0]              s_r_resp_o,
    output logic                    s_r_last_o,
    output logic [USER_WIDTH-1:0]   s_r_user_o,
    output logic [7:0]              m_aw_valid_o,
    input  logic [7:0]              m_aw_ready_i,
    output logic [ID_WIDTH-1:0]     m_aw_id_o,
    output logic [ADDR_WIDTH-1:0]   m_aw_addr_o,
    output logic [7:0]              m_aw_len_o,
    output logic [2:0]              m_aw_size_o,
    output logic [1:0]              m_aw_burst_o,
    output logic [USER_WIDTH-1:0]   m_aw_user_o,
    output logic [7:0]              m_w_valid_o,
    input  logic [7:0]              m_w_ready_i,
    output logic [DATA_WIDTH-1:0]   m_w_data_o,
    output logic [DATA_WIDTH/8-1:0] m_w_strb_o,
    output logic                    m_w_last_o,
    output logic [USER_WIDTH-1:0]   m_w_user_o,
    input  logic [7:0]              m_b_valid_i,
    output logic [7:0]              m_b_ready_o,
    input  logic [8*ID_WIDTH-1:0]   m_b_id_i,
    input  logic [15:0]             m_b_resp_i,
    input  logic [8*USER_WIDTH-1:0] m_b_user_i,
    output logic [7:0]              m_ar_valid_o,
    input  logic [7:0]              m_ar_ready_i,
    output logic [ID_WIDTH-1:0]     m_ar_id_o,
    output logic [ADDR_WIDTH-1:0]   m_ar_addr_o,
    output logic [7:0]              m_ar_len_o,
    output logic [2:0]              m_ar_size_o,
    output logic [1:0]              m_ar_burst_o,
    output logic [USER_WIDTH-1:0]   m_ar_user_o,
    input  logic [7:0]              m_r_valid_i,
    output logic [7:0]              m_r_ready_o,
    input  logic [8*ID_WIDTH-1:0]   m_r_id_i,
    input  logic [8*DATA_WIDTH-1:0] m_r_data_i,
    input  logic [15:0]             m_r_resp_i,
    input  logic [7:0]              m_r_last_i,
    input  logic [8*USER_WIDTH-1:0] m_r_user_i
);

    localparam int unsigned WCW = $clog2(W_MAX + 1);
    localparam int unsigned RCW = $clog2(R_MAX + 1);

    w_state_t       w_state_q, w_state_d;
    r_state_t       r_state_q, r_state_d;
    lane_t          w_port_q, w_port_d, r_port_q, r_port_d;
    logic [WCW-1:0] w_cnt_q, w_cnt_d;
    logic [RCW-1:0] r_cnt_q, r_cnt_d;
    logic           w_inc, w_dec, r_inc, r_dec;
    logic           aw_dec_hit, ar_dec_hit, aw_hit, ar_hit, w_block, r_block;
    logic [2:0]     aw_dec_sel, ar_dec_sel;
    lane_t          aw_sel, ar_sel;

`ifdef NASTI_DEMUX_DECERR_EN
    logic [ID_WIDTH-1:0]   err_w_id_q, err_w_id_d, err_r_id_q, err_r_id_d;
    logic [USER_WIDTH-1:0] err_w_user_q, err_w_user_d;
    logic [7:0]            err_r_len_q, err_r_len_d, err_r_beat_q, err_r_beat_d;
    assign aw_hit = aw_dec_hit;
    assign ar_hit = ar_dec_hit;
`else
    assign aw_hit = 1'b1;
    assign ar_hit = 1'b1;
`endif

    nasti_demux_decode #(
        .PORT_NUM(PORT_NUM), .ADDR_WIDTH(ADDR_WIDTH),
        .BASE0(BASE0), .BASE1(BASE1), .BASE2(BASE2), .BASE3(BASE3),
        .BASE4(BASE4), .BASE5(BASE5), .BASE6(BASE6), .BASE7(BASE7),
        .MASK0(MASK0), .MASK1(MASK1), .MASK2(MASK2), .MASK3(MASK3),
        .MASK4(MASK4), .MASK5(MASK5), .MASK6(MASK6), .MASK7(MASK7)
    ) u_aw_decode (.addr_i(s_aw_addr_i), .hit_o(aw_dec_hit), .sel_o(aw_dec_sel));

    nasti_demux_decode #(
        .PORT_NUM(PORT_NUM), .ADDR_WIDTH(ADDR_WIDTH),
        .BASE0(BASE0), .BASE1(BASE1), .BASE2(BASE2), .BASE3(BASE3),
        .BASE4(BASE4), .BASE5(BASE5), .BASE6(BASE6), .BASE7(BASE7),
        .MASK0(MASK0), .MASK1(MASK1), .MASK2(MASK2), .MASK3(MASK3),
        .MASK4(MASK4), .MASK5(MASK5), .MASK6(MASK6), .MASK7(MASK7)
    ) u_ar_decode (.addr_i(s_ar_addr_i), .hit_o(ar_dec_hit), .sel_o(ar_dec_sel));

    // A miss decodes to lane 0, which is where it goes when the error responder is absent.
    assign aw_sel = aw_dec_hit ? lane_t'(aw_dec_sel) : '0;
    assign ar_sel = ar_dec_hit ? lane_t'(ar_dec_sel) : '0;

    // Ordering: new requests only to the lane already holding outstanding ones.
    assign w_block = (w_cnt_q == WCW'(W_MAX)) ||
                     ((w_cnt_q != '0) && (!aw_hit || (aw_sel != w_port_q)));
    assign r_block = (r_cnt_q == RCW'(R_MAX)) ||
                     ((r_cnt_q != '0) && (!ar_hit || (ar_sel != r_port_q)));

    assign m_aw_id_o    = s_aw_id_i;
    assign m_aw_addr_o  = s_aw_addr_i;
    assign m_aw_len_o   = s_aw_len_i;
    assign m_aw_size_o  = s_aw_size_i;
    assign m_aw_burst_o = s_aw_burst_i;
    assign m_aw_user_o  = s_aw_user_i;
    assign m_w_data_o   = s_w_data_i;
    assign m_w_strb_o   = s_w_strb_i;
    assign m_w_last_o   = s_w_last_i;
    assign m_w_user_o   = s_w_user_i;
    assign m_ar_id_o    = s_ar_id_i;
    assign m_ar_addr_o  = s_ar_addr_i;
    assign m_ar_len_o   = s_ar_len_i;
    assign m_ar_size_o  = s_ar_size_i;
    assign m_ar_burst_o = s_ar_burst_i;
    assign m_ar_user_o  = s_ar_user_i;

    // Write direction: AW/W steering, B return and error responder.
    always_comb begin
        w_state_d    = w_state_q;
        w_port_d     = w_port_q;
        w_inc        = 1'b0;
        w_dec        = 1'b0;
        s_aw_ready_o = 1'b0;
        m_aw_valid_o = '0;
        s_w_ready_o  = 1'b0;
        m_w_valid_o  = '0;
        s_b_valid_o  = 1'b0;
        m_b_ready_o  = '0;
        s_b_id_o     = m_b_id_i[int'(w_port_q)*ID_WIDTH +: ID_WIDTH];
        s_b_resp_o   = m_b_resp_i[2*int'(w_port_q) +: 2];
        s_b_user_o   = m_b_user_i[int'(w_port_q)*USER_WIDTH +: USER_WIDTH];
`ifdef NASTI_DEMUX_DECERR_EN
        err_w_id_d   = err_w_id_q;
        err_w_user_d = err_w_user_q;
`endif
        if (!rst) begin
            case (w_state_q)
                W_IDLE: begin
                    if (aw_hit && !w_block) begin
                        m_aw_valid_o[aw_sel] = s_aw_valid_i;
                        s_aw_ready_o         = m_aw_ready_i[aw_sel];
                        if (s_aw_valid_i && m_aw_ready_i[aw_sel]) begin
                            w_inc     = 1'b1;
                            w_port_d  = aw_sel;
                            w_state_d = W_DATA;
                        end
                    end
`ifdef NASTI_DEMUX_DECERR_EN
                    else if (!aw_hit && (w_cnt_q == '0)) begin
                        s_aw_ready_o = 1'b1;
                        if (s_aw_valid_i) begin
                            err_w_id_d   = s_aw_id_i;
                            err_w_user_d = s_aw_user_i;
                            w_state_d    = W_ERR_DATA;
                        end
                    end
`endif
                end
                W_DATA: begin
                    m_w_valid_o[w_port_q] = s_w_valid_i;
                    s_w_ready_o           = m_w_ready_i[w_port_q];
                    if (s_w_valid_i && m_w_ready_i[w_port_q] && s_w_last_i) w_state_d = W_IDLE;
                end
`ifdef NASTI_DEMUX_DECERR_EN
                W_ERR_DATA: begin
                    s_w_ready_o = 1'b1;
                    if (s_w_valid_i && s_w_last_i) w_state_d = W_ERR_RESP;
                end
                W_ERR_RESP: begin
                    s_b_valid_o = 1'b1;
                    s_b_id_o    = err_w_id_q;
                    s_b_resp_o  = RESP_DECERR;
                    s_b_user_o  = err_w_user_q;
                    if (s_b_ready_i) w_state_d = W_IDLE;
                end
`endif
                default: ;
            endcase
            // Error responses only occur with nothing outstanding, so this never overlaps W_ERR_RESP.
            if (w_cnt_q != '0) begin
                s_b_valid_o           = m_b_valid_i[w_port_q];
                m_b_ready_o[w_port_q] = s_b_ready_i;
                w_dec                 = m_b_valid_i[w_port_q] && s_b_ready_i;
            end
        end
    end

    // Read direction: AR steering, R return and error responder.
    always_comb begin
        r_state_d    = r_state_q;
        r_port_d     = r_port_q;
        r_inc        = 1'b0;
        r_dec        = 1'b0;
        s_ar_ready_o = 1'b0;
        m_ar_valid_o = '0;
        s_r_valid_o  = 1'b0;
        m_r_ready_o  = '0;
        s_r_id_o     = m_r_id_i[int'(r_port_q)*ID_WIDTH +: ID_WIDTH];
        s_r_data_o   = m_r_data_i[int'(r_port_q)*DATA_WIDTH +: DATA_WIDTH];
        s_r_resp_o   = m_r_resp_i[2*int'(r_port_q) +: 2];
        s_r_last_o   = m_r_last_i[r_port_q];
        s_r_user_o   = m_r_user_i[int'(r_port_q)*USER_WIDTH +: USER_WIDTH];
`ifdef NASTI_DEMUX_DECERR_EN
        err_r_id_d   = err_r_id_q;
        err_r_len_d  = err_r_len_q;
        err_r_beat_d = err_r_beat_q;
`endif
        if (!rst) begin
            case (r_state_q)
                R_IDLE: begin
                    if (ar_hit && !r_block) begin
                        m_ar_valid_o[ar_sel] = s_ar_valid_i;
                        s_ar_ready_o         = m_ar_ready_i[ar_sel];
                        if (s_ar_valid_i && m_ar_ready_i[ar_sel]) begin
                            r_inc    = 1'b1;
                            r_port_d = ar_sel;
                        end
                    end
`ifdef NASTI_DEMUX_DECERR_EN
                    else if (!ar_hit && (r_cnt_q == '0)) begin
                        s_ar_ready_o = 1'b1;
                        if (s_ar_valid_i) begin
                            err_r_id_d   = s_ar_id_i;
                            err_r_len_d  = s_ar_len_i;
                            err_r_beat_d = '0;
                            r_state_d    = R_ERR;
                        end
                    end
`endif
                end
`ifdef NASTI_DEMUX_DECERR_EN
                R_ERR: begin
                    s_r_valid_o = 1'b1;
                    s_r_id_o    = err_r_id_q;
                    s_r_data_o  = '0;
                    s_r_resp_o  = RESP_DECERR;
                    s_r_last_o  = (err_r_beat_q == err_r_len_q);
                    s_r_user_o  = '0;
                    if (s_r_ready_i) begin
                        err_r_beat_d = err_r_beat_q + 8'd1;
                        if (err_r_beat_q == err_r_len_q) r_state_d = R_IDLE;
                    end
                end
`endif
                default: ;
            endcase
            if (r_cnt_q != '0) begin
                s_r_valid_o           = m_r_valid_i[r_port_q];
                m_r_ready_o[r_port_q] = s_r_ready_i;
                r_dec = m_r_valid_i[r_port_q] && s_r_ready_i && m_r_last_i[r_port_q];
            end
        end
    end

    always_comb begin
        w_cnt_d = w_cnt_q;
        r_cnt_d = r_cnt_q;
        if (w_inc && !w_dec) w_cnt_d = w_cnt_q + WCW'(1);
        if (!w_inc && w_dec) w_cnt_d = w_cnt_q - WCW'(1);
        if (r_inc && !r_dec) r_cnt_d = r_cnt_q + RCW'(1);
        if (!r_inc && r_dec) r_cnt_d = r_cnt_q - RCW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            w_port_q  <= '0;
            r_port_q  <= '0;
            w_cnt_q   <= '0;
            r_cnt_q   <= '0;
`ifdef NASTI_DEMUX_DECERR_EN
            err_w_id_q   <= '0;
            err_w_user_q <= '0;
            err_r_id_q   <= '0;
            err_r_len_q  <= '0;
            err_r_beat_q <= '0;
`endif
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            w_port_q  <= w_port_d;
            r_port_q  <= r_port_d;
            w_cnt_q   <= w_cnt_d;
            r_cnt_q   <= r_cnt_d;
`ifdef NASTI_DEMUX_DECERR_EN
            err_w_id_q   <= err_w_id_d;
            err_w_user_q <= err_w_user_d;
            err_r_id_q   <= err_r_id_d;
            err_r_len_q  <= err_r_len_d;
            err_r_beat_q <= err_r_beat_d;
`endif
        end
    end

endmodule
